// File: rtl/seven_segment_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
// Glyph table, segment bit positions and inactive-level helper.
package seven_segment_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [SEG_W-1:0] GLYPH_0 = 7'b1111110;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'b1101101;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'b1111001;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'b0110011;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'b1011011;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'b1011111;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'b1110000;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'b1110011;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'b1110111;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'b0011111;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'b1001110;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'b0111101;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'b1001111;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'b1000111;

  // Pin level meaning "off" for a given polarity.
  function automatic logic off_level(input logic active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/seven_segment_glyph.sv
// Hex nibble to logical (active-high) segment pattern.
// Purely combinational lookup.
module seven_segment_glyph
  import seven_segment_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] seg_o
);

  // Table lookup of the 16 hex glyphs.
  always_comb begin
    seg_o = '0;
    unique case (nibble_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      4'hF: seg_o = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed hex display driver with dead-time,
// frame-synchronous double buffering and output polarity control.
module seven_segment_scan
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int DEAD_CYCLES    = 500,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int LZ_BLANK       = 1
) (
  input  logic                    CLK_IN,
  input  logic                    RST_IN,
  input  logic [4*NUM_DIGITS-1:0] VALUE_IN,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  input  logic [NUM_DIGITS-1:0]   BLANK_IN,
  input  logic                    LOAD_IN,
  output logic                    PENDING_OUT,
  output logic [SEG_W-1:0]        SEG_OUT,
  output logic                    DP_OUT,
  output logic [NUM_DIGITS-1:0]   DIGIT_OUT,
  output logic                    FRAME_OUT
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic SEG_OFF = off_level(SEG_ACTIVE_LOW != 0);
  localparam logic DIG_OFF = off_level(DIG_ACTIVE_LOW != 0);

  logic [PW-1:0] p_q, p_d;
  logic [DW-1:0] d_q, d_d;

  logic [VW-1:0]         act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] act_blk_q, act_blk_d;
  logic [VW-1:0]         pnd_val_q, pnd_val_d;
  logic [NUM_DIGITS-1:0] pnd_dp_q, pnd_dp_d;
  logic [NUM_DIGITS-1:0] pnd_blk_q, pnd_blk_d;
  logic                  pnd_q, pnd_d;

  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  frame_q;

  logic slot_end, frame_end;
  logic show, hi_zero, lz_dark, dark;
  logic [3:0]       nibble;
  logic [SEG_W-1:0] glyph;

  assign slot_end  = (p_q == PW'(CLK_DIV - 1));
  assign frame_end = slot_end && (d_q == DW'(NUM_DIGITS - 1));

  // Prescaler and digit index advance.
  always_comb begin
    p_d = slot_end ? '0 : p_q + 1'b1;
    d_d = d_q;
    if (slot_end) begin
      d_d = frame_end ? '0 : d_q + 1'b1;
    end
  end

  // Pending/active buffer handoff; active only changes on a frame edge.
  always_comb begin
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    act_blk_d = act_blk_q;
    pnd_val_d = pnd_val_q;
    pnd_dp_d  = pnd_dp_q;
    pnd_blk_d = pnd_blk_q;
    pnd_d     = pnd_q;
    if (frame_end) begin
      pnd_d = 1'b0;
      if (LOAD_IN) begin
        act_val_d = VALUE_IN;
        act_dp_d  = DP_IN;
        act_blk_d = BLANK_IN;
      end else if (pnd_q) begin
        act_val_d = pnd_val_q;
        act_dp_d  = pnd_dp_q;
        act_blk_d = pnd_blk_q;
      end
    end else if (LOAD_IN) begin
      pnd_val_d = VALUE_IN;
      pnd_dp_d  = DP_IN;
      pnd_blk_d = BLANK_IN;
      pnd_d     = 1'b1;
    end
  end

  // Leading-zero test: this digit and every higher one are zero.
  always_comb begin
    hi_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (DW'(k) >= d_q && act_val_q[4*k +: 4] != 4'h0) begin
        hi_zero = 1'b0;
      end
    end
  end

  assign nibble  = act_val_q[{d_q, 2'b00} +: 4];
  assign lz_dark = (LZ_BLANK != 0) && (d_q != '0) && hi_zero;
  assign dark    = act_blk_q[d_q] || lz_dark;
  assign show    = (DEAD_CYCLES == 0) || (p_q >= PW'(DEAD_CYCLES));

  seven_segment_glyph u_glyph (
    .nibble_i (nibble),
    .seg_o    (glyph)
  );

  // Logical (active-high) pin values for the current slot.
  always_comb begin
    dig_d = show ? (NUM_DIGITS'(1) << d_q) : '0;
    seg_d = (show && !dark) ? glyph : '0;
    dp_d  = show && !dark && act_dp_q[d_q];
  end

  // Scan counters and display buffers.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      p_q       <= '0;
      d_q       <= '0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      act_blk_q <= '0;
      pnd_val_q <= '0;
      pnd_dp_q  <= '0;
      pnd_blk_q <= '0;
      pnd_q     <= 1'b0;
    end else begin
      p_q       <= p_d;
      d_q       <= d_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      act_blk_q <= act_blk_d;
      pnd_val_q <= pnd_val_d;
      pnd_dp_q  <= pnd_dp_d;
      pnd_blk_q <= pnd_blk_d;
      pnd_q     <= pnd_d;
    end
  end

  // Output registers; polarity is applied only here.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      seg_q   <= {SEG_W{SEG_OFF}};
      dp_q    <= SEG_OFF;
      dig_q   <= {NUM_DIGITS{DIG_OFF}};
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_d ^ {SEG_W{SEG_OFF}};
      dp_q    <= dp_d ^ SEG_OFF;
      dig_q   <= dig_d ^ {NUM_DIGITS{DIG_OFF}};
      frame_q <= frame_end;
    end
  end

  assign SEG_OUT     = seg_q;
  assign DP_OUT      = dp_q;
  assign DIGIT_OUT   = dig_q;
  assign FRAME_OUT   = frame_q;
  assign PENDING_OUT = pnd_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Scoreboard bench for seven_segment_scan: three instances
// (default, leading-zero blanking, inverted polarity) share stimulus.
module tb_seven_segment_scan;

  localparam int N  = 4;
  localparam int CD = 8;
  localparam int DC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        load;
  logic [15:0] val;
  logic [3:0]  dp;
  logic [3:0]  blank;

  logic       pend_a, dp_a, frm_a;
  logic [6:0] seg_a;
  logic [3:0] dig_a;
  logic       pend_b, dp_b, frm_b;
  logic [6:0] seg_b;
  logic [3:0] dig_b;
  logic       pend_c, dp_c, frm_c;
  logic [6:0] seg_c;
  logic [3:0] dig_c;

  seven_segment_scan #(
    .NUM_DIGITS(N), .CLK_DIV(CD), .DEAD_CYCLES(DC),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1), .LZ_BLANK(0)
  ) u_a (
    .CLK_IN(clk), .RST_IN(rst), .VALUE_IN(val), .DP_IN(dp),
    .BLANK_IN(blank), .LOAD_IN(load), .PENDING_OUT(pend_a),
    .SEG_OUT(seg_a), .DP_OUT(dp_a), .DIGIT_OUT(dig_a),
    .FRAME_OUT(frm_a)
  );

  seven_segment_scan #(
    .NUM_DIGITS(N), .CLK_DIV(CD), .DEAD_CYCLES(DC),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1), .LZ_BLANK(1)
  ) u_b (
    .CLK_IN(clk), .RST_IN(rst), .VALUE_IN(val), .DP_IN(dp),
    .BLANK_IN(blank), .LOAD_IN(load), .PENDING_OUT(pend_b),
    .SEG_OUT(seg_b), .DP_OUT(dp_b), .DIGIT_OUT(dig_b),
    .FRAME_OUT(frm_b)
  );

  seven_segment_scan #(
    .NUM_DIGITS(N), .CLK_DIV(CD), .DEAD_CYCLES(DC),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0), .LZ_BLANK(0)
  ) u_c (
    .CLK_IN(clk), .RST_IN(rst), .VALUE_IN(val), .DP_IN(dp),
    .BLANK_IN(blank), .LOAD_IN(load), .PENDING_OUT(pend_c),
    .SEG_OUT(seg_c), .DP_OUT(dp_c), .DIGIT_OUT(dig_c),
    .FRAME_OUT(frm_c)
  );

  logic [6:0] GLY [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  typedef struct {
    logic [6:0] s0;
    logic [6:0] s1;
    logic       d0;
    logic       d1;
    logic [3:0] dig;
    logic       pend;
    logic       frame;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int          mp, md;
  logic [15:0] av, pv;
  logic [3:0]  adp, ablk, pdp, pblk;
  logic        pf;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Drive one cycle and predict the registered outputs after the edge.
  task automatic step(input logic r, input logic ld,
                      input logic [15:0] v, input logic [3:0] p,
                      input logic [3:0] b);
    exp_t e;
    int   nib;
    bit   show, lz, dk0, dk1, bnd;
    @(negedge clk);
    rst = r; load = ld; val = v; dp = p; blank = b;
    e.s0 = '0; e.s1 = '0; e.d0 = 1'b0; e.d1 = 1'b0;
    e.dig = '0; e.pend = 1'b0; e.frame = 1'b0;
    if (r) begin
      mp = 0; md = 0; av = '0; pv = '0;
      adp = '0; ablk = '0; pdp = '0; pblk = '0; pf = 1'b0;
    end else begin
      show = (mp >= DC);
      nib  = int'(av >> (4 * md)) & 15;
      lz   = (md > 0) && ((av >> (4 * md)) == 16'h0);
      dk0  = ablk[md];
      dk1  = dk0 || lz;
      if (show) e.dig = 4'(1 << md);
      if (show && !dk0) begin
        e.s0 = GLY[nib];
        e.d0 = adp[md];
      end
      if (show && !dk1) begin
        e.s1 = GLY[nib];
        e.d1 = adp[md];
      end
      bnd = (mp == CD - 1) && (md == N - 1);
      e.frame = bnd;
      if (bnd) begin
        if (ld) begin
          av = v; adp = p; ablk = b;
        end else if (pf) begin
          av = pv; adp = pdp; ablk = pblk;
        end
        pf = 1'b0;
      end else if (ld) begin
        pv = v; pdp = p; pblk = b; pf = 1'b1;
      end
      if (mp == CD - 1) begin
        mp = 0;
        md = (md + 1) % N;
      end else begin
        mp = mp + 1;
      end
      e.pend = pf;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 16'($urandom), 4'($urandom),
                    4'($urandom));
  endtask

  task automatic ld(input logic [15:0] v, input logic [3:0] p);
    step(1'b0, 1'b1, v, p, 4'h0);
  endtask

  // Monitor: compare every instance against the queued prediction.
  initial begin
    exp_t e;
    logic [6:0] ns0;
    logic       nd0;
    logic [3:0] ndig;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        ns0  = ~e.s0;
        nd0  = ~e.d0;
        ndig = ~e.dig;
        chk("a_seg", 32'(seg_a), 32'(e.s0));
        chk("a_dp", 32'(dp_a), 32'(e.d0));
        chk("a_dig", 32'(dig_a), 32'(ndig));
        chk("a_pend", 32'(pend_a), 32'(e.pend));
        chk("a_frame", 32'(frm_a), 32'(e.frame));
        chk("b_seg", 32'(seg_b), 32'(e.s1));
        chk("b_dp", 32'(dp_b), 32'(e.d1));
        chk("b_dig", 32'(dig_b), 32'(ndig));
        chk("b_pend", 32'(pend_b), 32'(e.pend));
        chk("b_frame", 32'(frm_b), 32'(e.frame));
        chk("c_seg", 32'(seg_c), 32'(ns0));
        chk("c_dp", 32'(dp_c), 32'(nd0));
        chk("c_dig", 32'(dig_c), 32'(e.dig));
        chk("c_pend", 32'(pend_c), 32'(e.pend));
        chk("c_frame", 32'(frm_c), 32'(e.frame));
      end
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; val = '0; dp = '0; blank = '0;
    mp = 0; md = 0; av = '0; pv = '0;
    adp = '0; ablk = '0; pdp = '0; pblk = '0; pf = 1'b0;

    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

    ld(16'h1234, 4'h0);
    idle(80);

    for (int i = 0; i < 64 && !(md == 1 && mp == 2); i++) idle(1);
    ld(16'hABCD, 4'h5);
    idle(5);
    ld(16'hEF01, 4'hA);
    idle(70);

    for (int i = 0; i < 64 && !(md == N-1 && mp == CD-1); i++)
      idle(1);
    ld(16'h5555, 4'h0);
    idle(40);

    ld(16'h0040, 4'h1);
    idle(70);
    ld(16'h0000, 4'h0);
    idle(70);
    ld(16'h0008, 4'h0);
    idle(70);

    for (int i = 0; i < 64 && !(md == 2 && mp == 4); i++) idle(1);
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(40);

    for (int i = 0; i < 2500; i++) begin
      logic [15:0] v;
      v = ($urandom_range(0, 1) != 0) ? 16'($urandom)
                                     : 16'($urandom_range(0, 255));
      step($urandom_range(0, 399) == 0, $urandom_range(0, 15) == 0,
           v, 4'($urandom),
           4'($urandom) & 4'($urandom) & 4'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan.md
Name: seven_segment_scan

Overview:
- Multi-digit, time-multiplexed hex display driver for the common-segment / per-digit-enable LED displays on the board.
- Holds a double-buffered NUM_DIGITS-nibble value and scans one digit per refresh slot.
- Adds dead-time between digits against ghosting, tear-free frame-boundary updates, per-digit decimal point and blanking, optional leading-zero suppression, and selectable output polarities.
- Sits between application logic (counters, debug registers) and the display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- CLK_DIV, 50000, CLK_IN cycles per digit slot (>= DEAD_CYCLES+2).
- DEAD_CYCLES, 500, cycles at start of each slot with all digit enables inactive (>= 0, < CLK_DIV).
- SEG_ACTIVE_LOW, 0, 1 inverts SEG_OUT and DP_OUT.
- DIG_ACTIVE_LOW, 1, 1 inverts DIGIT_OUT.
- LZ_BLANK, 1, 1 enables leading-zero suppression.

Ports:
- CLK_IN  input  1  system clock.
- RST_IN  input  1  synchronous reset, active-high.
- VALUE_IN  input  4*NUM_DIGITS  hex value; nibble k drives digit k, digit 0 least significant.
- DP_IN  input  NUM_DIGITS  decimal point per digit.
- BLANK_IN  input  NUM_DIGITS  force digit k dark.
- LOAD_IN  input  1  capture VALUE_IN/DP_IN/BLANK_IN into the pending buffer.
- PENDING_OUT  output  1  pending buffer not yet applied.
- SEG_OUT  output  7  segments, bit6=a .. bit0=g.
- DP_OUT  output  1  decimal-point segment.
- DIGIT_OUT  output  NUM_DIGITS  one-hot digit enable.
- FRAME_OUT  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- One clock; reset is synchronous and active-high on RST_IN; all state updates on posedge CLK_IN.
- Glyphs (logical, active-high), 0..F:
  - 0-7: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000.
  - 8-F: 1111111, 1110011, 1110111, 0011111, 1001110, 0111101, 1001111, 1000111.
- Counters:
  - Prescaler P: 0..CLK_DIV-1, wraps to 0.
  - Index D: increments when P=CLK_DIV-1; wraps NUM_DIGITS-1 -> 0.
  - Frame boundary: P=CLK_DIV-1 and D=NUM_DIGITS-1.
- Slot phases: DEAD (P < DEAD_CYCLES) then SHOW (P >= DEAD_CYCLES). DEAD_CYCLES=0 means no DEAD phase.
- All outputs are registered and reflect (P, D, active buffer) of the previous cycle, i.e. 1-cycle latency.
- DEAD phase: DIGIT_OUT all inactive, SEG_OUT/DP_OUT inactive.
- SHOW phase, digit D visible:
  - DIGIT_OUT bit D active, others inactive.
  - SEG_OUT = glyph(active nibble D); DP_OUT = active DP[D].
- Digit D is dark (segments and DP inactive, enable still active) when either holds:
  - BLANK[D]=1;
  - LZ_BLANK=1, D>0, and nibbles D..NUM_DIGITS-1 are all zero.
  - Digit 0 is never leading-zero blanked.
- Buffering:
  - LOAD_IN=1 copies inputs into pending and sets PENDING_OUT the next cycle.
  - Repeated loads before a boundary: last one wins.
  - At a boundary: pending -> active, PENDING_OUT clears.
  - LOAD_IN on the boundary cycle: the input data goes straight to active and PENDING_OUT stays 0.
- FRAME_OUT=1 for exactly the cycle after each boundary.
- Reset (also mid-scan):
  - P=0, D=0; pending, active and PENDING_OUT cleared to 0.
  - FRAME_OUT=0; DIGIT_OUT/SEG_OUT/DP_OUT at their inactive polarity levels.
  - Scanning resumes from digit 0, DEAD phase, on the cycle after release.
- Polarity applied only at the output registers; internal logic is active-high.

Decomposition:
- Package seven_segment_pkg: 16 glyph constants, segment bit-order constants, inactive-level helper function.
- Sub-module seven_segment_glyph: combinational 4-bit -> 7-bit lookup from package constants. Instantiated once, on the muxed nibble.
- Top keeps prescaler, index, phase, buffers, blanking and output registers.

Test Plan:
- Use NUM_DIGITS=4, CLK_DIV=8, DEAD_CYCLES=2, SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=1, LZ_BLANK=0 unless a scenario states otherwise.
- Reset/scan: load 0x1234 and reach a boundary.
  - Each slot: 2 cycles DIGIT_OUT=1111, then 6 cycles with DIGIT_OUT=1110,1101,1011,0111 in turn.
  - SEG_OUT per slot: 0110011, 1111001, 1101101, 0110000.
  - FRAME_OUT pulses every 32 cycles.
- Double buffer: LOAD 0xABCD mid-frame, then 0xEF01 before the boundary.
  - PENDING_OUT=1 until the boundary.
  - Current frame still shows the old value; next frame shows 0xEF01.
- Boundary-cycle LOAD: LOAD 0x5555 on the boundary cycle -> PENDING_OUT stays 0; next frame digit 0 SEG_OUT=1011011.
- Leading zeros: LZ_BLANK=1, value 0x0040, DP_IN=0001.
  - Digits 3 and 2 dark; digit 1 shows 0110011; digit 0 shows 1111110 with DP_OUT=1.
  - Value 0x0000: only digit 0 lit.
- Mid-scan reset: assert RST_IN during digit 2 SHOW.
  - Next cycle: DIGIT_OUT=1111, SEG_OUT=0000000, active=0.
  - After release: digit 0 DEAD then SHOW of 1111110.
- Polarity: SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=0, value 0x8 on digit 0 -> SEG_OUT=0000000 while lit, DIGIT_OUT=0001; inactive levels 1111111/0000.
